// File: rtl/brimstone_pkg.sv
// Shared encodings for the multicycle controller:
// opcodes, funct codes, ALU controls, mux selects and states.
package brimstone_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_wr_en;
    logic       ir_wr_en;
    logic       iord_sel;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic       reg_wr_en;
    logic       reg_wr_addr_sel;
    logic       reg_wr_data_sel;
    logic       alu_src_a_sel;
    logic [1:0] alu_src_b_sel;
    logic [1:0] pc_src_sel;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  // S_FETCH doubles as "unsupported opcode".
  function automatic state_t decode_target(logic [5:0] op);
    state_t s;
    s = S_FETCH;
    unique case (1'b1)
      (op == OP_RTYPE):               s = S_REXEC;
      (op == OP_LW), (op == OP_SW):   s = S_MEMADR;
      (op == OP_BEQ):                 s = S_BEQEX;
      (op == OP_ADDI):                s = S_ADDIEX;
      (op == OP_J):                   s = S_JEX;
      default:                        s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller
// and the datapath / memory it steers.
interface multicycle_controller_if #(
  parameter int OP_WIDTH_P        = 6,
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int ALU_CNTRL_WIDTH_P = 3
);
  logic [OP_WIDTH_P-1:0]        i_opcode;
  logic [FUNCT_WIDTH_P-1:0]     i_function;
  logic                         i_zero;
  logic                         i_mem_rdy;
  logic                         o_pc_wr_en;
  logic                         o_ir_wr_en;
  logic                         o_iord_sel;
  logic                         o_mem_rd_en;
  logic                         o_mem_wr_en;
  logic                         o_reg_wr_en;
  logic                         o_reg_wr_addr_sel;
  logic                         o_reg_wr_data_sel;
  logic                         o_alu_src_a_sel;
  logic [1:0]                   o_alu_src_b_sel;
  logic [1:0]                   o_pc_src_sel;
  logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl;
  logic                         o_retire;
  logic                         o_illegal;

  modport master (
    input  i_opcode, i_function, i_zero, i_mem_rdy,
    output o_pc_wr_en, o_ir_wr_en, o_iord_sel,
    output o_mem_rd_en, o_mem_wr_en,
    output o_reg_wr_en, o_reg_wr_addr_sel,
    output o_reg_wr_data_sel,
    output o_alu_src_a_sel, o_alu_src_b_sel,
    output o_pc_src_sel, o_alu_cntrl,
    output o_retire, o_illegal
  );

  modport slave (
    output i_opcode, i_function, i_zero, i_mem_rdy,
    input  o_pc_wr_en, o_ir_wr_en, o_iord_sel,
    input  o_mem_rd_en, o_mem_wr_en,
    input  o_reg_wr_en, o_reg_wr_addr_sel,
    input  o_reg_wr_data_sel,
    input  o_alu_src_a_sel, o_alu_src_b_sel,
    input  o_pc_src_sel, o_alu_cntrl,
    input  o_retire, o_illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps ALU op class plus R-type funct to an ALU control
// code; funct_valid flags funct codes outside the table.
module alu_decoder
  import brimstone_pkg::*;
#(
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int ALU_CNTRL_WIDTH_P = 3
) (
  input  logic [1:0]                   alu_op,
  input  logic [FUNCT_WIDTH_P-1:0]     funct,
  output logic [ALU_CNTRL_WIDTH_P-1:0] alu_cntrl,
  output logic                         funct_valid
);

  localparam int W = ALU_CNTRL_WIDTH_P;
  localparam int F = FUNCT_WIDTH_P;

  logic [W-1:0] funct_cntrl;

  // Validity is independent of alu_op so DECODE can use it.
  always_comb begin
    funct_cntrl = W'(ALU_ADD);
    funct_valid = 1'b1;
    unique case (1'b1)
      (funct == F'(FN_ADD)): funct_cntrl = W'(ALU_ADD);
      (funct == F'(FN_SUB)): funct_cntrl = W'(ALU_SUB);
      (funct == F'(FN_AND)): funct_cntrl = W'(ALU_AND);
      (funct == F'(FN_OR)):  funct_cntrl = W'(ALU_OR);
      (funct == F'(FN_SLT)): funct_cntrl = W'(ALU_SLT);
      default:               funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_cntrl = W'(ALU_ADD);
    unique case (1'b1)
      (alu_op == ALUOP_SUB):   alu_cntrl = W'(ALU_SUB);
      (alu_op == ALUOP_FUNCT): alu_cntrl = funct_cntrl;
      default:                 alu_cntrl = W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style controller: FSM state register
// plus combinational control decode and sticky illegal flag.
module multicycle_controller
  import brimstone_pkg::*;
#(
  parameter int OP_WIDTH_P        = 6,
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int ALU_CNTRL_WIDTH_P = 3
) (
  input logic                   i_clk,
  input logic                   i_rst,
  multicycle_controller_if.master bus
);

  state_t                       state;
  state_t                       state_nxt;
  state_t                       target;
  ctrl_t                        c;
  logic                         illegal_q;
  logic                         dec_illegal;
  logic                         funct_valid;
  logic [ALU_CNTRL_WIDTH_P-1:0] alu_cntrl;
  logic [OP_WIDTH_P-1:0]        opcode;
  logic [5:0]                   op;
  logic                         rdy;

  assign opcode = bus.i_opcode;
  assign op     = 6'(opcode);
  assign rdy    = bus.i_mem_rdy;
  assign target = decode_target(op);

  assign dec_illegal = (target == S_FETCH) ||
                       (target == S_REXEC && !funct_valid);

  alu_decoder #(
    .FUNCT_WIDTH_P     (FUNCT_WIDTH_P),
    .ALU_CNTRL_WIDTH_P (ALU_CNTRL_WIDTH_P)
  ) u_alu_decoder (
    .alu_op      (c.alu_op),
    .funct       (bus.i_function),
    .alu_cntrl   (alu_cntrl),
    .funct_valid (funct_valid)
  );

  always_comb begin
    c         = '0;
    c.alu_op  = ALUOP_ADD;
    state_nxt = state;
    unique case (state)
      S_FETCH: begin
        c.mem_rd_en     = 1'b1;
        c.alu_src_b_sel = SRCB_FOUR;
        c.ir_wr_en      = rdy;
        c.pc_wr_en      = rdy;
        if (rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b_sel = SRCB_SHIFT;
        if (dec_illegal) begin
          c.retire  = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = target;
        end
      end
      S_MEMADR: begin
        c.alu_src_a_sel = 1'b1;
        c.alu_src_b_sel = SRCB_SEXT;
        state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.iord_sel  = 1'b1;
        c.mem_rd_en = 1'b1;
        if (rdy) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.reg_wr_en       = 1'b1;
        c.reg_wr_data_sel = 1'b1;
        c.retire          = 1'b1;
        state_nxt         = S_FETCH;
      end
      S_MEMWR: begin
        c.iord_sel  = 1'b1;
        c.mem_wr_en = 1'b1;
        c.retire    = rdy;
        if (rdy) state_nxt = S_FETCH;
      end
      S_REXEC: begin
        c.alu_src_a_sel = 1'b1;
        c.alu_src_b_sel = SRCB_REG;
        c.alu_op        = ALUOP_FUNCT;
        state_nxt       = S_RWB;
      end
      S_RWB: begin
        c.reg_wr_en       = 1'b1;
        c.reg_wr_addr_sel = 1'b1;
        c.retire          = 1'b1;
        state_nxt         = S_FETCH;
      end
      S_BEQEX: begin
        c.alu_src_a_sel = 1'b1;
        c.alu_src_b_sel = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_src_sel    = PCSRC_ALUOUT;
        c.pc_wr_en      = bus.i_zero;
        c.retire        = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_ADDIEX: begin
        c.alu_src_a_sel = 1'b1;
        c.alu_src_b_sel = SRCB_SEXT;
        state_nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.reg_wr_en = 1'b1;
        c.retire    = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_JEX: begin
        c.pc_src_sel = PCSRC_JUMP;
        c.pc_wr_en   = 1'b1;
        c.retire     = 1'b1;
        state_nxt    = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE && dec_illegal)
        illegal_q <= 1'b1;
    end
  end

  // Reset overrides FETCH's request without waiting for an edge.
  assign bus.o_pc_wr_en        = c.pc_wr_en  & ~i_rst;
  assign bus.o_ir_wr_en        = c.ir_wr_en  & ~i_rst;
  assign bus.o_mem_rd_en       = c.mem_rd_en & ~i_rst;
  assign bus.o_mem_wr_en       = c.mem_wr_en & ~i_rst;
  assign bus.o_reg_wr_en       = c.reg_wr_en & ~i_rst;
  assign bus.o_retire          = c.retire    & ~i_rst;
  assign bus.o_iord_sel        = c.iord_sel;
  assign bus.o_reg_wr_addr_sel = c.reg_wr_addr_sel;
  assign bus.o_reg_wr_data_sel = c.reg_wr_data_sel;
  assign bus.o_alu_src_a_sel   = c.alu_src_a_sel;
  assign bus.o_alu_src_b_sel   = c.alu_src_b_sel;
  assign bus.o_pc_src_sel      = c.pc_src_sel;
  assign bus.o_alu_cntrl       = alu_cntrl;
  assign bus.o_illegal         = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction
// expected cycle tables checked every cycle, plus reset cases.
module tb_multicycle_controller;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       addr_sel;
    logic       data_sel;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [2:0] alu;
    logic       retire;
    logic       illegal;
  } vec_t;

  typedef struct {
    logic rdy;
    vec_t exp;
  } step_t;

  typedef enum {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_ILL} kind_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  exp_cur;
  logic  chk      = 1'b0;
  int    cyc      = 0;
  int    ret_at   = 0;
  logic  ill_m    = 1'b0;
  string cur_name = "";
  step_t q[$];

  function automatic vec_t actual();
    vec_t v;
    v.pc_wr    = bus.o_pc_wr_en;
    v.ir_wr    = bus.o_ir_wr_en;
    v.iord     = bus.o_iord_sel;
    v.mem_rd   = bus.o_mem_rd_en;
    v.mem_wr   = bus.o_mem_wr_en;
    v.reg_wr   = bus.o_reg_wr_en;
    v.addr_sel = bus.o_reg_wr_addr_sel;
    v.data_sel = bus.o_reg_wr_data_sel;
    v.src_a    = bus.o_alu_src_a_sel;
    v.src_b    = bus.o_alu_src_b_sel;
    v.pc_src   = bus.o_pc_src_sel;
    v.alu      = bus.o_alu_cntrl;
    v.retire   = bus.o_retire;
    v.illegal  = bus.o_illegal;
    return v;
  endfunction

  always @(negedge i_clk) begin
    if (chk) begin
      cyc++;
      n_checks++;
      if (actual() !== exp_cur) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h",
                 cur_name, cyc, actual(), exp_cur);
      end
      if (bus.o_retire === 1'b1 && ret_at == 0) ret_at = cyc;
    end
  end

  function automatic logic [2:0] funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic kind_t classify(logic [5:0] op, logic [5:0] f);
    case (op)
      6'b000000: begin
        case (f)
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b101010: return K_R;
          default: return K_ILL;
        endcase
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic vec_t base();
    vec_t v;
    v = '0;
    v.alu = 3'b010;
    v.illegal = ill_m;
    return v;
  endfunction

  function automatic step_t mk(logic rdy, vec_t v);
    step_t s;
    s.rdy = rdy;
    s.exp = v;
    return s;
  endfunction

  // Expected cycle table for one instruction, from the ISA rules.
  task automatic build(input logic [5:0] op, input logic [5:0] f,
                       input logic z, input int fw, input int mw);
    vec_t  v;
    kind_t k;
    q.delete();
    k = classify(op, f);
    for (int i = 0; i <= fw; i++) begin
      v = base();
      v.mem_rd = 1'b1;
      v.src_b = 2'b01;
      v.ir_wr = (i == fw);
      v.pc_wr = (i == fw);
      q.push_back(mk(i == fw, v));
    end
    v = base();
    v.src_b = 2'b11;
    v.retire = (k == K_ILL);
    q.push_back(mk(1'b1, v));
    if (k == K_ILL) begin
      ill_m = 1'b1;
      return;
    end
    case (k)
      K_R: begin
        v = base(); v.src_a = 1; v.src_b = 2'b00;
        v.alu = funct_alu(f);
        q.push_back(mk(1'b1, v));
        v = base(); v.reg_wr = 1; v.addr_sel = 1; v.retire = 1;
        q.push_back(mk(1'b1, v));
      end
      K_LW, K_SW: begin
        v = base(); v.src_a = 1; v.src_b = 2'b10;
        q.push_back(mk(1'b1, v));
        for (int i = 0; i <= mw; i++) begin
          v = base(); v.iord = 1;
          v.mem_rd = (k == K_LW);
          v.mem_wr = (k == K_SW);
          v.retire = (k == K_SW) && (i == mw);
          q.push_back(mk(i == mw, v));
        end
        if (k == K_LW) begin
          v = base(); v.reg_wr = 1; v.data_sel = 1; v.retire = 1;
          q.push_back(mk(1'b1, v));
        end
      end
      K_BEQ: begin
        v = base(); v.src_a = 1; v.src_b = 2'b00; v.alu = 3'b110;
        v.pc_src = 2'b01; v.pc_wr = z; v.retire = 1;
        q.push_back(mk(1'b1, v));
      end
      K_ADDI: begin
        v = base(); v.src_a = 1; v.src_b = 2'b10;
        q.push_back(mk(1'b1, v));
        v = base(); v.reg_wr = 1; v.retire = 1;
        q.push_back(mk(1'b1, v));
      end
      default: begin
        v = base(); v.pc_src = 2'b10; v.pc_wr = 1; v.retire = 1;
        q.push_back(mk(1'b1, v));
      end
    endcase
  endtask

  // Called just after a rising edge; leaves just after one.
  task automatic run(input string name, input logic [5:0] op,
                     input logic [5:0] f, input logic z,
                     input int fw, input int mw, input int lat,
                     input int limit);
    int n;
    build(op, f, z, fw, mw);
    cur_name = name;
    bus.i_opcode = op;
    bus.i_function = f;
    bus.i_zero = z;
    cyc = 0;
    ret_at = 0;
    n = (limit > 0) ? limit : q.size();
    chk = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.i_mem_rdy = q[i].rdy;
      exp_cur = q[i].exp;
      @(posedge i_clk);
      #1;
    end
    chk = 1'b0;
    if (limit <= 0) begin
      n_checks++;
      if (ret_at != lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d",
                 name, ret_at, lat);
      end
    end
  endtask

  task automatic check_rst_quiet(input string name);
    vec_t a;
    a = actual();
    n_checks++;
    if ({a.pc_wr, a.ir_wr, a.mem_rd, a.mem_wr, a.reg_wr,
         a.retire, a.illegal} !== 7'b0) begin
      n_fail++;
      $display("FAIL %s: got %h want enables/retire/illegal 0",
               name, a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    bus.i_opcode = '0;
    bus.i_function = '0;
    bus.i_zero = 1'b0;
    bus.i_mem_rdy = 1'b1;
    #2;
    check_rst_quiet("reset_t0");
    @(posedge i_clk);
    #1;
    check_rst_quiet("reset_edge");
    i_rst = 1'b0;

    run("r_add",  6'b000000, 6'b100000, 0, 0, 0, 4, 0);
    run("r_sub",  6'b000000, 6'b100010, 1, 0, 0, 4, 0);
    run("r_and",  6'b000000, 6'b100100, 0, 1, 0, 5, 0);
    run("r_or",   6'b000000, 6'b100101, 0, 0, 0, 4, 0);
    run("r_slt",  6'b000000, 6'b101010, 0, 0, 0, 4, 0);
    run("lw_w2",  6'b100011, 6'b000000, 0, 0, 2, 7, 0);
    run("lw",     6'b100011, 6'b000000, 0, 0, 0, 5, 0);
    run("sw",     6'b101011, 6'b000000, 0, 0, 0, 4, 0);
    run("sw_w1",  6'b101011, 6'b000000, 0, 0, 1, 5, 0);
    run("beq_z1", 6'b000100, 6'b000000, 1, 0, 0, 3, 0);
    run("beq_z0", 6'b000100, 6'b000000, 0, 0, 0, 3, 0);
    run("addi",   6'b001000, 6'b000000, 0, 0, 0, 4, 0);
    run("j",      6'b000010, 6'b000000, 0, 2, 0, 5, 0);
    run("r_badfn",6'b000000, 6'b111111, 0, 0, 0, 2, 0);
    run("ill_op", 6'b111111, 6'b100000, 0, 0, 0, 2, 0);
    run("sticky", 6'b000000, 6'b100000, 0, 0, 0, 4, 0);

    // Stall a store in MEMWR, then reset mid-cycle.
    run("sw_stall", 6'b101011, 6'b000000, 0, 0, 5, 0, 4);
    bus.i_mem_rdy = 1'b0;
    #1;
    n_checks++;
    if (bus.o_mem_wr_en !== 1'b1 || bus.o_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: got wr=%b ill=%b want wr=1 ill=1",
               bus.o_mem_wr_en, bus.o_illegal);
    end
    i_rst = 1'b1;
    #1;
    check_rst_quiet("rst_midcycle");
    @(posedge i_clk);
    #1;
    check_rst_quiet("rst_held");
    i_rst = 1'b0;
    ill_m = 1'b0;
    run("after_rst", 6'b000000, 6'b100000, 0, 0, 0, 4, 0);
    run("addi_end",  6'b001000, 6'b000000, 1, 0, 0, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
